// File: rtl/generador_nivel_comida.sv
// Food level generator: seconds-timebase decay/refill of a 2-bit level, with a manual test mode.
// Optional macro NIVEL_COMIDA_7SEG_EN adds a registered 7-segment decode of the level.
module generador_nivel_comida #(
    parameter int TICK_DIV    = 50_000_000,
    parameter int DECAY_TICKS = 10,
    parameter int FEED_TICKS  = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       Activo_Comida,
    input  logic       Senal_MTest,
    input  logic       Senal_Test_fil,
    output logic [1:0] Nivel_Comida,
    output logic       Nivel_Cambio,
    output logic       tick_1s,
    output logic [6:0] Nivel_7seg
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DW = (DECAY_TICKS > 1) ? $clog2(DECAY_TICKS) : 1;
    localparam int FW = (FEED_TICKS > 1) ? $clog2(FEED_TICKS) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DECAY_LAST = DW'(DECAY_TICKS - 1);
    localparam logic [FW-1:0] FEED_LAST  = FW'(FEED_TICKS - 1);

    typedef enum logic [1:0] {
        DECAY = 2'd0,
        FEED  = 2'd1,
        TEST  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [DW-1:0]   decay_q, decay_d;
    logic [FW-1:0]   feed_q, feed_d;
    logic [1:0]      level_q, level_d;
    logic            cambio_q, cambio_d;
    logic            sync_p0, sync_p1, sync_p2, fall_p3;
    logic            tick;

    // Button path: two-flop synchroniser, history flop, registered falling-edge pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            sync_p2 <= 1'b0;
            fall_p3 <= 1'b0;
        end else begin
            sync_p0 <= Senal_Test_fil;
            sync_p1 <= sync_p0;
            sync_p2 <= sync_p1;
            fall_p3 <= sync_p2 & ~sync_p1;
        end
    end

    assign tick = (state_q != TEST) && (presc_q == PRESC_LAST);

    always_comb begin
        state_d  = state_q;
        decay_d  = decay_q;
        feed_d   = feed_q;
        level_d  = level_q;
        presc_d  = (presc_q == PRESC_LAST) ? '0 : presc_q + 1'b1;
        if (Senal_MTest || state_q == TEST)
            presc_d = '0;

        case (state_q)
            DECAY: begin
                if (Senal_MTest) begin
                    state_d = TEST;
                    decay_d = '0;
                    feed_d  = '0;
                end else if (!Activo_Comida) begin
                    state_d = FEED;
                    decay_d = '0;
                    feed_d  = '0;
                end else if (tick) begin
                    if (decay_q == DECAY_LAST) begin
                        decay_d = '0;
                        if (level_q != 2'd0)
                            level_d = level_q - 2'd1;
                    end else begin
                        decay_d = decay_q + 1'b1;
                    end
                end
            end
            FEED: begin
                if (Senal_MTest) begin
                    state_d = TEST;
                    decay_d = '0;
                    feed_d  = '0;
                end else if (Activo_Comida) begin
                    state_d = DECAY;
                    decay_d = '0;
                    feed_d  = '0;
                end else if (tick) begin
                    if (feed_q == FEED_LAST) begin
                        feed_d = '0;
                        if (level_q != 2'd3)
                            level_d = level_q + 2'd1;
                    end else begin
                        feed_d = feed_q + 1'b1;
                    end
                end
            end
            TEST: begin
                decay_d = '0;
                feed_d  = '0;
                if (!Senal_MTest)
                    state_d = DECAY;
                else if (fall_p3)
                    level_d = level_q - 2'd1;   // 2-bit wrap takes 0 back to 3
            end
            default: begin
                state_d = DECAY;
                decay_d = '0;
                feed_d  = '0;
            end
        endcase

        cambio_d = (level_d != level_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= DECAY;
            presc_q  <= '0;
            decay_q  <= '0;
            feed_q   <= '0;
            level_q  <= 2'd3;
            cambio_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            presc_q  <= presc_d;
            decay_q  <= decay_d;
            feed_q   <= feed_d;
            level_q  <= level_d;
            cambio_q <= cambio_d;
        end
    end

    assign Nivel_Comida = level_q;
    assign Nivel_Cambio = cambio_q;
    assign tick_1s      = tick;

`ifdef NIVEL_COMIDA_7SEG_EN
    // Display stage: one cycle behind the level, active-low {g,f,e,d,c,b,a}
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            Nivel_7seg <= 7'b1111111;
        end else begin
            case (level_q)
                2'd0:    Nivel_7seg <= 7'b1000000;
                2'd1:    Nivel_7seg <= 7'b1111001;
                2'd2:    Nivel_7seg <= 7'b0100100;
                default: Nivel_7seg <= 7'b0110000;
            endcase
        end
    end
`else
    assign Nivel_7seg = 7'b1111111;
`endif

endmodule
